// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with ID/EX pipeline register, operand forwarding,
// single-cycle ALU, branch target, zero flag and an iterative shift-add multiplier.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_stall_in                   downstream hold; freezes ID/EX and the multiplier
//   id_flush                      load a bubble into ID/EX on an advance edge
//   id_valid, id_wreg, id_m2reg,
//   id_wmem, id_branch, id_shift,
//   id_aluimm, id_aluc            decode controls
//   id_fwda, id_fwdb              forward select (0/3 regfile, 1 MEM, 2 WB)
//   id_a_in, id_b_in, id_imm,
//   id_pc4, id_destR              operands, immediate, PC+4, destination
//   mem_fwd_data, wb_fwd_data     live forwarding sources
//   ex_valid, ex_wreg, ex_m2reg,
//   ex_wmem, ex_branch            controls to EX/MEM
//   ex_aluR, ex_inB, ex_pc        ALU result, forwarded store data, branch target
//   ex_destR, ex_zero             destination register, fa == fb
//   ex_busy                       multiplier occupies EX; hazard unit holds PC and IF/ID
module ex_stage_mc #(
  parameter int XLEN     = 32,
  parameter int SHW      = $clog2(XLEN),
  parameter int BR_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_stall_in,
  input  logic            id_flush,
  input  logic            id_valid,
  input  logic            id_wreg,
  input  logic            id_m2reg,
  input  logic            id_wmem,
  input  logic            id_branch,
  input  logic            id_shift,
  input  logic            id_aluimm,
  input  logic [3:0]      id_aluc,
  input  logic [1:0]      id_fwda,
  input  logic [1:0]      id_fwdb,
  input  logic [XLEN-1:0] id_a_in,
  input  logic [XLEN-1:0] id_b_in,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc4,
  input  logic [4:0]      id_destR,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  output logic            ex_wreg,
  output logic            ex_m2reg,
  output logic            ex_wmem,
  output logic            ex_branch,
  output logic [XLEN-1:0] ex_aluR,
  output logic [XLEN-1:0] ex_inB,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_destR,
  output logic            ex_zero,
  output logic            ex_busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // ID/EX register
  logic            r_valid, r_wreg, r_m2reg, r_wmem, r_branch, r_shift, r_aluimm;
  logic [3:0]      r_aluc;
  logic [1:0]      r_fwda, r_fwdb;
  logic [XLEN-1:0] r_a, r_b, r_imm, r_pc4;
  logic [4:0]      r_destR;

  // Multiplier state
  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_mcand, r_mplier, r_acc;
  logic [XLEN-1:0] w_mcand_d, w_mplier_d, w_acc_d;
  logic [SHW-1:0]  r_cnt, w_cnt_d;

  logic            w_busy, w_advance, w_is_mul;
  logic [XLEN-1:0] w_fa, w_fb, w_opa, w_opb, w_sa_ext, w_alu;

  assign w_is_mul  = r_valid && (r_aluc == 4'd12);
  assign w_advance = !w_busy && !ex_stall_in;

  always_ff @(posedge clk) begin
    if (rst || (w_advance && id_flush)) begin
      r_valid  <= 1'b0;
      r_wreg   <= 1'b0;
      r_m2reg  <= 1'b0;
      r_wmem   <= 1'b0;
      r_branch <= 1'b0;
      r_shift  <= 1'b0;
      r_aluimm <= 1'b0;
      r_aluc   <= '0;
      r_fwda   <= '0;
      r_fwdb   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_pc4    <= '0;
      r_destR  <= '0;
    end else if (w_advance) begin
      r_valid  <= id_valid;
      r_wreg   <= id_wreg;
      r_m2reg  <= id_m2reg;
      r_wmem   <= id_wmem;
      r_branch <= id_branch;
      r_shift  <= id_shift;
      r_aluimm <= id_aluimm;
      r_aluc   <= id_aluc;
      r_fwda   <= id_fwda;
      r_fwdb   <= id_fwdb;
      r_a      <= id_a_in;
      r_b      <= id_b_in;
      r_imm    <= id_imm;
      r_pc4    <= id_pc4;
      r_destR  <= id_destR;
    end
  end

  // Forwarding muxes; selects 0 and 3 both mean regfile.
  always_comb begin
    unique case (r_fwda)
      2'd1:    w_fa = mem_fwd_data;
      2'd2:    w_fa = wb_fwd_data;
      default: w_fa = r_a;
    endcase
    unique case (r_fwdb)
      2'd1:    w_fb = mem_fwd_data;
      2'd2:    w_fb = wb_fwd_data;
      default: w_fb = r_b;
    endcase
  end

  assign w_sa_ext = {{(XLEN-SHW){1'b0}}, r_imm[6+SHW-1:6]};
  assign w_opa    = r_shift ? w_sa_ext : w_fa;
  assign w_opb    = r_aluimm ? r_imm : w_fb;

  always_comb begin
    w_alu = '0;
    unique case (r_aluc)
      4'd0:    w_alu = w_opa + w_opb;
      4'd1:    w_alu = w_opa - w_opb;
      4'd2:    w_alu = w_opa & w_opb;
      4'd3:    w_alu = w_opa | w_opb;
      4'd4:    w_alu = w_opa ^ w_opb;
      4'd5:    w_alu = ~(w_opa | w_opb);
      4'd6:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_opa) < $signed(w_opb))};
      4'd7:    w_alu = {{(XLEN-1){1'b0}}, (w_opa < w_opb)};
      4'd8:    w_alu = w_opb << w_opa[SHW-1:0];
      4'd9:    w_alu = w_opb >> w_opa[SHW-1:0];
      4'd10:   w_alu = $unsigned($signed(w_opb) >>> w_opa[SHW-1:0]);
      4'd11:   w_alu = w_opb << (XLEN/2);
      default: w_alu = '0; // MUL result comes from the accumulator in StDone
    endcase
  end

  // Multiplier FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_acc    <= w_acc_d;
      r_cnt    <= w_cnt_d;
    end
  end

  // Multiplier FSM: next state and busy
  always_comb begin
    w_state_d  = r_state;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_acc_d    = r_acc;
    w_cnt_d    = r_cnt;
    w_busy     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_is_mul) begin
          w_busy = 1'b1;
          if (!ex_stall_in) begin
            w_mcand_d  = w_opa;
            w_mplier_d = w_opb;
            w_acc_d    = '0;
            w_cnt_d    = '0;
            w_state_d  = StRun;
          end
        end
      end
      StRun: begin
        w_busy = 1'b1;
        if (!ex_stall_in) begin
          if (r_mplier[0]) w_acc_d = r_acc + r_mcand;
          w_mcand_d  = r_mcand << 1;
          w_mplier_d = r_mplier >> 1;
          w_cnt_d    = r_cnt + 1'b1;
          if (r_cnt == SHW'(XLEN-1)) w_state_d = StDone;
        end
      end
      StDone: begin
        // Busy is low here, so advance reduces to !ex_stall_in.
        if (!ex_stall_in) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // While the multiply is in flight EX/MEM must see a bubble.
  assign ex_valid  = r_valid  && !w_busy;
  assign ex_wreg   = r_wreg   && !w_busy;
  assign ex_wmem   = r_wmem   && !w_busy;
  assign ex_branch = r_branch && !w_busy;
  assign ex_m2reg  = r_m2reg;
  assign ex_destR  = r_destR;
  assign ex_inB    = w_fb;
  assign ex_aluR   = (r_state == StDone) ? r_acc : w_alu;
  assign ex_pc     = r_pc4 + (r_imm << BR_SHIFT);
  // Gated by valid so a bubble (and the post-reset state) reads zero everywhere.
  assign ex_zero   = r_valid && (w_fa == w_fb);
  assign ex_busy   = w_busy;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed testbench for ex_stage_mc at the default 32-bit width.
module tb_ex_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_stall_in, id_flush, id_valid, id_wreg, id_m2reg, id_wmem;
  logic        id_branch, id_shift, id_aluimm;
  logic [3:0]  id_aluc;
  logic [1:0]  id_fwda, id_fwdb;
  logic [31:0] id_a_in, id_b_in, id_imm, id_pc4;
  logic [4:0]  id_destR;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero, ex_busy;
  logic [31:0] ex_aluR, ex_inB, ex_pc;
  logic [4:0]  ex_destR;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  ex_stage_mc dut (
    .clk(clk), .rst(rst), .ex_stall_in(ex_stall_in), .id_flush(id_flush),
    .id_valid(id_valid), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_branch(id_branch), .id_shift(id_shift), .id_aluimm(id_aluimm),
    .id_aluc(id_aluc), .id_fwda(id_fwda), .id_fwdb(id_fwdb),
    .id_a_in(id_a_in), .id_b_in(id_b_in), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_destR(id_destR), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_branch(ex_branch), .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_pc(ex_pc),
    .ex_destR(ex_destR), .ex_zero(ex_zero), .ex_busy(ex_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic id_clear();
    id_valid = 0; id_wreg = 0; id_m2reg = 0; id_wmem = 0; id_branch = 0;
    id_shift = 0; id_aluimm = 0; id_aluc = 0; id_fwda = 0; id_fwdb = 0;
    id_a_in = 0; id_b_in = 0; id_imm = 0; id_pc4 = 0; id_destR = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; ex_stall_in = 0; id_flush = 0;
    mem_fwd_data = 0; wb_fwd_data = 0;
    id_clear();
    step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_aluR", ex_aluR, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_zero", ex_zero, 0);
    chk("rst_busy", ex_busy, 0);
    chk("rst_destR", ex_destR, 0);
    rst = 0;

    // ADD with A forwarded from MEM
    id_valid = 1; id_wreg = 1; id_fwda = 1; mem_fwd_data = 7; id_b_in = 5;
    id_aluc = 0; id_destR = 3;
    step();
    chk("add_aluR", ex_aluR, 32'd12);
    chk("add_zero", ex_zero, 0);
    chk("add_valid", ex_valid, 1);
    chk("add_destR", ex_destR, 5'd3);

    // SRA by shamt field of imm
    id_clear(); id_valid = 1; id_shift = 1; id_imm = 32'd4 << 6;
    id_b_in = 32'h8000_0000; id_aluc = 10;
    step();
    chk("sra_aluR", ex_aluR, 32'hF800_0000);

    // Branch target and zero flag
    id_clear(); id_valid = 1; id_branch = 1; id_pc4 = 32'h100; id_imm = 3;
    id_a_in = 9; id_b_in = 9; id_aluc = 1;
    step();
    chk("br_pc", ex_pc, 32'h10C);
    chk("br_zero", ex_zero, 1);
    chk("br_branch", ex_branch, 1);
    chk("br_sub", ex_aluR, 0);

    // XOR with B forwarded from WB
    id_clear(); id_valid = 1; id_fwdb = 2; wb_fwd_data = 32'h55; id_a_in = 32'h0F;
    id_aluc = 4;
    step();
    chk("xor_aluR", ex_aluR, 32'h5A);
    chk("xor_inB", ex_inB, 32'h55);

    // SLT / SLTU on -1 vs 1
    id_clear(); id_valid = 1; id_a_in = 32'hFFFF_FFFF; id_b_in = 1; id_aluc = 6;
    step();
    chk("slt", ex_aluR, 1);
    id_aluc = 7;
    step();
    chk("sltu", ex_aluR, 0);

    // NOR and LUI
    id_clear(); id_valid = 1; id_a_in = 32'hF0F0_F0F0; id_b_in = 32'h0F0F_0000; id_aluc = 5;
    step();
    chk("nor", ex_aluR, 32'h0000_0F0F);
    id_clear(); id_valid = 1; id_aluimm = 1; id_imm = 32'h1234; id_aluc = 11;
    step();
    chk("lui", ex_aluR, 32'h1234_0000);

    // Stall holds ID/EX
    id_clear(); id_valid = 1; id_wreg = 1; id_wmem = 1; id_a_in = 1; id_b_in = 2;
    id_destR = 5;
    step();
    chk("stl_load", ex_aluR, 3);
    ex_stall_in = 1; id_a_in = 100; id_destR = 9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_aluR", ex_aluR, 3);
      chk("stl_destR", ex_destR, 5'd5);
    end
    ex_stall_in = 0; id_flush = 1;
    step();
    chk("fl_valid", ex_valid, 0);
    chk("fl_wreg", ex_wreg, 0);
    chk("fl_wmem", ex_wmem, 0);
    id_flush = 0;

    // MUL: A = 0xFFFFFFFF via MEM forward, B = 3
    id_clear(); id_valid = 1; id_wreg = 1; id_fwda = 1; mem_fwd_data = 32'hFFFF_FFFF;
    id_b_in = 3; id_aluc = 12; id_destR = 7;
    step();
    // Younger instruction waits in ID
    id_clear(); id_valid = 1; id_wreg = 1; id_a_in = 10; id_b_in = 20; id_destR = 9;
    busy_cnt = 0;
    while (ex_busy && busy_cnt < 100) begin
      chk("mul_vld0", ex_valid, 0);
      if (busy_cnt > 0) mem_fwd_data = $urandom;
      busy_cnt++;
      step();
    end
    chk("mul_busy_cycles", busy_cnt, 33);
    chk("mul_prod", ex_aluR, 32'hFFFF_FFFD);
    chk("mul_valid", ex_valid, 1);
    chk("mul_destR", ex_destR, 5'd7);
    step();
    chk("post_mul_add", ex_aluR, 32'd30);
    chk("post_mul_busy", ex_busy, 0);

    // Reset in the middle of RUN
    id_clear(); id_valid = 1; id_wreg = 1; id_a_in = 5; id_b_in = 7; id_aluc = 12;
    id_destR = 4;
    step();
    for (int i = 0; i < 11; i++) step();
    chk("rm_busy_pre", ex_busy, 1);
    rst = 1;
    step();
    rst = 0; id_clear();
    chk("rm_busy", ex_busy, 0);
    chk("rm_aluR", ex_aluR, 0);
    chk("rm_destR", ex_destR, 0);
    chk("rm_valid", ex_valid, 0);
    chk("rm_pc", ex_pc, 0);
    step();
    chk("rm_idle", ex_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
